// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_stream
//  Description : Read-side drain stage for a synchronous FIFO with one-cycle
//                read latency. Issues reads while the FIFO is non-empty and
//                space remains, captures returning words into a 2-entry
//                skid buffer and presents them in order on a valid/ready
//                stream at up to one word per clock. Counts delivered words.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_WIDTH        width of FIFO words and stream data
//    CNT_WIDTH         width of the delivered-word counter
//  Ports
//    clk               clock, rising edge
//    rst               asynchronous active-high reset
//    fifo_empty_i      FIFO empty flag
//    fifo_data_out_i   FIFO read data, valid the cycle after a read request
//    fifo_underflow_i  FIFO underflow flag, same timing as read data
//    fifo_rd_en_o      read request to the FIFO
//    m_valid_o         stream data valid
//    m_ready_i         downstream accepts
//    m_data_o          stream data (head of buffer)
//    xfer_cnt_o        count of words accepted downstream (wraps)
//    rd_err_o          sticky read error
//  Build option
//    FIFO_RD_UNDERFLOW_CHK_EN  when defined, an in-flight word flagged by
//                              fifo_underflow_i is dropped and rd_err_o
//                              latches high until reset; otherwise the flag
//                              is ignored and rd_err_o is tied low.
// ============================================================================
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_out_i,
    input  logic                  fifo_underflow_i,
    output logic                  fifo_rd_en_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [CNT_WIDTH-1:0]  xfer_cnt_o,
    output logic                  rd_err_o
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            occ_q;
    logic [1:0]            occ_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf0_q;
    logic [DATA_WIDTH-1:0] buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q;
    logic [DATA_WIDTH-1:0] buf1_d;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic                  w_pop;
    logic                  w_capture;
    logic                  w_uf_hit;
    logic [2:0]            w_level;

    assign w_pop = (occ_q != 2'd0) && m_ready_i;

    // Words that will still occupy the buffer after this edge, counting the
    // one already in flight from the FIFO. A pop only happens with occ>=1,
    // so the subtraction cannot wrap.
    assign w_level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, w_pop};

    assign fifo_rd_en_o = !rst && !fifo_empty_i && (w_level < 3'd2);

`ifdef FIFO_RD_UNDERFLOW_CHK_EN
    logic rd_err_q;

    assign w_uf_hit = inflight_q && fifo_underflow_i;
    assign rd_err_o = rd_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_err_q <= 1'b0;
        end else if (w_uf_hit) begin
            rd_err_q <= 1'b1;
        end
    end
`else
    logic w_unused_underflow;

    assign w_unused_underflow = fifo_underflow_i;
    assign w_uf_hit           = 1'b0;
    assign rd_err_o           = 1'b0;
`endif

    assign w_capture = inflight_q && !w_uf_hit;

    // Shift first, then write the captured word at the first free slot of
    // the shifted buffer. This covers capture-with-pop at occ=1 (new word
    // lands in entry 0) and at occ=2 (entry 1 moves down, new word in 1).
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q;
        if (w_pop) begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 2'd1;
        end
        if (w_capture) begin
            if (occ_d == 2'd0) begin
                buf0_d = fifo_data_out_i;
            end else begin
                buf1_d = fifo_data_out_i;
            end
            occ_d = occ_d + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en_o;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            if (w_pop) begin
                cnt_q <= cnt_q + C_CNT_ONE;
            end
        end
    end

    assign m_valid_o  = (occ_q != 2'd0);
    assign m_data_o   = buf0_q;
    assign xfer_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_stream
//  Description : Directed self-checking bench for fifo_rd_stream with a
//                simple one-cycle-latency FIFO model in front of it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_rd_stream;

    localparam int DW = 16;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_underflow;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] xfer_cnt;
    logic          rd_err;

    // FIFO model inputs
    logic          wr_en;
    logic [DW-1:0] wr_data;

    int n_checks;
    int n_errors;

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fifo_empty_i     (fifo_empty),
        .fifo_data_out_i  (fifo_data_out),
        .fifo_underflow_i (fifo_underflow),
        .fifo_rd_en_o     (fifo_rd_en),
        .m_valid_o        (m_valid),
        .m_ready_i        (m_ready),
        .m_data_o         (m_data),
        .xfer_cnt_o       (xfer_cnt),
        .rd_err_o         (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous FIFO model: read data registered one cycle after rd_en.
    logic [DW-1:0] fmem [0:2047];
    int            wp;
    int            rp;

    assign fifo_empty = (wp == rp);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wp            <= 0;
            rp            <= 0;
            fifo_data_out <= '0;
        end else begin
            if (fifo_rd_en) begin
                fifo_data_out <= fmem[rp];
                rp            <= rp + 1;
            end
            if (wr_en) begin
                fmem[wp] <= wr_data;
                wp       <= wp + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int            rdcnt;
        int            sent;
        int            got;
        int            cyc;
        int            xfer_exp;
        logic [DW-1:0] sb [$];
        logic [DW-1:0] exp_w;
        logic          pv;
        logic          pr;
        logic [DW-1:0] pd;
        logic          found;

        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        wr_en          = 1'b0;
        wr_data        = '0;
        m_ready        = 1'b0;
        fifo_underflow = 1'b0;

        // ---------------- reset values
        #1;
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_data", {16'd0, m_data}, 32'd0);
        chk("rst_xfer", {16'd0, xfer_cnt}, 32'd0);
        chk("rst_err", {31'd0, rd_err}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ---------------- single word
        m_ready = 1'b1;
        wr_en   = 1'b1;
        wr_data = 16'hA5A5;
        #1;
        chk("single_rd_empty", {31'd0, fifo_rd_en}, 32'd0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("single_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        chk("single_valid_n", {31'd0, m_valid}, 32'd0);
        tick();
        #1;
        chk("single_rd_en1", {31'd0, fifo_rd_en}, 32'd0);
        chk("single_valid_n1", {31'd0, m_valid}, 32'd0);
        tick();
        #1;
        chk("single_valid", {31'd0, m_valid}, 32'd1);
        chk("single_data", {16'd0, m_data}, 32'h0000A5A5);
        tick();
        #1;
        chk("single_valid_off", {31'd0, m_valid}, 32'd0);
        chk("single_xfer", {16'd0, xfer_cnt}, 32'd1);
        tick();

        // ---------------- burst of 16, ready held high
        for (int c = 0; c < 24; c++) begin
            wr_en   = (c < 16);
            wr_data = 16'(c + 1);
            #1;
            chk("burst_valid", {31'd0, m_valid}, {31'd0, (c >= 3 && c <= 18)});
            if (c >= 3 && c <= 18) begin
                chk("burst_data", {16'd0, m_data}, 32'(c - 2));
            end
            tick();
        end
        wr_en = 1'b0;
        #1;
        chk("burst_xfer", {16'd0, xfer_cnt}, 32'd17);

        // ---------------- backpressure
        m_ready = 1'b0;
        rdcnt   = 0;
        for (int c = 0; c < 12; c++) begin
            wr_en   = (c < 8);
            wr_data = 16'(16'h0100 + c);
            #1;
            if (fifo_rd_en) rdcnt++;
            chk("bp_valid", {31'd0, m_valid}, {31'd0, (c >= 3)});
            if (c >= 3) begin
                chk("bp_hold_data", {16'd0, m_data}, 32'h00000100);
            end
            tick();
        end
        wr_en = 1'b0;
        chk("bp_reads", 32'(rdcnt), 32'd2);
        for (int i = 0; i < 8; i++) begin
            m_ready = 1'b1;
            #1;
            chk("bp_rel_valid", {31'd0, m_valid}, 32'd1);
            chk("bp_rel_data", {16'd0, m_data}, 32'(16'h0100 + i));
            tick();
        end
        #1;
        chk("bp_drained", {31'd0, m_valid}, 32'd0);
        chk("bp_xfer", {16'd0, xfer_cnt}, 32'd25);

        // ---------------- random ready, 500 random words
        sent = 0;
        got  = 0;
        cyc  = 0;
        pv   = 1'b0;
        pr   = 1'b0;
        pd   = '0;
        while (got < 500 && cyc < 20000) begin
            wr_en   = (sent < 500) && ($urandom_range(0, 3) != 0);
            wr_data = 16'($urandom);
            if (wr_en) begin
                sb.push_back(wr_data);
                sent++;
            end
            m_ready = 1'($urandom_range(0, 1));
            #1;
            if (pv && !pr) begin
                chk("rnd_hold_valid", {31'd0, m_valid}, 32'd1);
                chk("rnd_hold_data", {16'd0, m_data}, {16'd0, pd});
            end
            if (fifo_empty) begin
                chk("rnd_rd_empty", {31'd0, fifo_rd_en}, 32'd0);
            end
            if (m_valid && m_ready) begin
                exp_w = (sb.size() > 0) ? sb[0] : 16'hxxxx;
                if (sb.size() > 0) void'(sb.pop_front());
                chk("rnd_order", {16'd0, m_data}, {16'd0, exp_w});
                got++;
            end
            pv = m_valid;
            pr = m_ready;
            pd = m_data;
            tick();
            cyc++;
        end
        wr_en = 1'b0;
        chk("rnd_count", 32'(got), 32'd500);
        #1;
        xfer_exp = 525;
        chk("rnd_xfer", {16'd0, xfer_cnt}, 32'(xfer_exp));

        // ---------------- underflow on the in-flight cycle
        m_ready = 1'b1;
        wr_en   = 1'b1;
        wr_data = 16'h5A5A;
        tick();
        wr_en = 1'b0;
        #1;
        chk("uf_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        tick();
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        #1;
`ifdef FIFO_RD_UNDERFLOW_CHK_EN
        chk("uf_no_capture", {31'd0, m_valid}, 32'd0);
        chk("uf_err_set", {31'd0, rd_err}, 32'd1);
        tick();
        tick();
        #1;
        chk("uf_err_sticky", {31'd0, rd_err}, 32'd1);
        chk("uf_xfer", {16'd0, xfer_cnt}, 32'd525);
`else
        chk("uf_captured", {31'd0, m_valid}, 32'd1);
        chk("uf_data", {16'd0, m_data}, 32'h00005A5A);
        chk("uf_err_zero", {31'd0, rd_err}, 32'd0);
        tick();
        tick();
        #1;
        chk("uf_err_zero2", {31'd0, rd_err}, 32'd0);
        chk("uf_xfer", {16'd0, xfer_cnt}, 32'd526);
`endif

        // ---------------- reset mid-stream with a full buffer
        m_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            wr_en   = (c < 3);
            wr_data = 16'(16'h0C01 + c);
            tick();
        end
        wr_en = 1'b0;
        #1;
        chk("mr_pre_valid", {31'd0, m_valid}, 32'd1);
        chk("mr_pre_data", {16'd0, m_data}, 32'h00000C01);
        rst = 1'b1;
        #1;
        chk("mr_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("mr_valid", {31'd0, m_valid}, 32'd0);
        chk("mr_data", {16'd0, m_data}, 32'd0);
        chk("mr_xfer", {16'd0, xfer_cnt}, 32'd0);
        chk("mr_err", {31'd0, rd_err}, 32'd0);
        tick();
        tick();
        rst     = 1'b0;
        m_ready = 1'b1;
        wr_en   = 1'b1;
        wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (!found && m_valid) begin
                found = 1'b1;
                chk("mr_first_word", {16'd0, m_data}, 32'h0000BEEF);
            end
            tick();
        end
        chk("mr_found", {31'd0, found}, 32'd1);
        #1;
        chk("mr_post_xfer", {16'd0, xfer_cnt}, 32'd1);
        chk("mr_post_valid", {31'd0, m_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain stage sitting directly downstream of the synchronous FIFO. It issues `fifo_rd_en` whenever the FIFO is non-empty and it has room, hides the FIFO's one-cycle read latency, and presents words in order on a valid/ready stream through a 2-entry skid buffer. Full throughput is one word per clock. It also counts delivered words.

## Interface
- `DATA_WIDTH`, 16, width of FIFO words and stream data.
- `CNT_WIDTH`, 16, width of the delivered-word counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data_out`  in  DATA_WIDTH  FIFO read data; valid the cycle after a sampled `fifo_rd_en`.
- `fifo_underflow`  in  1  FIFO underflow flag; same timing as `fifo_data_out`.
- `fifo_rd_en`  out  1  read request to the FIFO.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  DATA_WIDTH  stream data (head of buffer).
- `xfer_cnt`  out  CNT_WIDTH  words accepted downstream.
- `rd_err`  out  1  sticky read error (see Configuration).

## Operation
- **State:**
  - `occ` (0..2) is the number of buffered words.
  - `inflight` is 1 when `fifo_rd_en` was asserted in the previous cycle.
  - `pop = m_valid && m_ready`.
- **Read request:** `fifo_rd_en = !rst && !fifo_empty && (occ + inflight - pop) < 2`.
  - This is combinational from `m_ready`, `fifo_empty`, and state.
- **Capture:** when `inflight` is 1, `fifo_data_out` is written to the tail at the edge.
- **Stream output:**
  - `m_valid = (occ != 0)`.
  - `m_data` is always entry 0.
  - On `pop`, entry 1 shifts to entry 0.
- **Simultaneous capture and pop:**
  - `occ` is unchanged.
  - When `occ`=1, the captured word goes to entry 0.
  - When `occ`=2, entry 1 shifts to entry 0 and the captured word goes to entry 1.
- **Order:** FIFO order is preserved strictly. No word is dropped or duplicated.
- **Counter:** `xfer_cnt` increments on every `pop` and wraps modulo 2^CNT_WIDTH.
- **Holding valid data:** `m_data` and `m_valid` hold stable while `m_valid && !m_ready`.
- **Reset mid-operation:**
  - The buffer and in-flight word are discarded.
  - `occ`, `inflight`, `xfer_cnt` and `rd_err` go to 0.
  - The FIFO is reset by the same system reset.

## Timing
- **Reset values:** `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `xfer_cnt`=0, `rd_err`=0.
- **Latency:** FIFO non-empty with `occ`=0 and `inflight`=0:
  - `fifo_rd_en` is asserted in cycle N.
  - Data is captured at the end of N+1.
  - `m_valid`=1 in cycle N+2.
- **Throughput:** sustained one word per clock while the FIFO is non-empty and `m_ready`=1.
- **Backpressure:**
  - With `m_ready`=0, at most 2 words are held, counting in-flight.
  - `fifo_rd_en` drops once `occ + inflight` = 2.
- **FIFO empty:** `fifo_rd_en` is 0 in any cycle `fifo_empty`=1. The adapter never requests a read from an empty FIFO.

## Configuration
- **Macro:** `FIFO_RD_UNDERFLOW_CHK_EN`.
- **Defined:**
  - In a cycle with `inflight`=1 and `fifo_underflow`=1, the word is not captured and `occ` does not increment.
  - `rd_err` sets to 1 and stays set until `rst`.
- **Undefined:**
  - `fifo_underflow` is ignored and every in-flight word is captured.
  - `rd_err` is tied to 0.

## Test plan
- **Reset:** assert `rst` mid-stream with `occ`=2 → all outputs 0 immediately; after release, the first delivered word is the first post-reset FIFO write.
- **Single word:** write 0xA5A5 to the FIFO with `m_ready`=1 → `fifo_rd_en` asserted 1 cycle, `m_valid`/`m_data`=0xA5A5 for exactly 1 cycle, `xfer_cnt`=1.
- **Burst:** write 0x0001..0x0010 back-to-back with `m_ready`=1 → 16 consecutive `m_valid` cycles, in order, `xfer_cnt`=16.
- **Backpressure:** 8 words queued with `m_ready`=0 for 10 cycles → exactly 2 FIFO reads, `m_data`=first word held stable; release → remaining words in order with no gaps.
- **Random ready:** toggle `m_ready` randomly over 500 random words → scoreboard order matches and `xfer_cnt` equals the number of accepted words.
- **Underflow (macro defined):** force `fifo_underflow`=1 on an in-flight cycle → no word captured, `rd_err`=1 until `rst`. With the macro undefined → `rd_err`=0.
